mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multi-cycle sequencing controller for the RV32 core. It replaces the single-cycle opcode decode with a Moore/Mealy FSM that steps a shared ALU, a unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback. It sits beside the datapath, reads the opcode from the instruction register, and drives all mux selects and write strobes. Memory accesses use a req/ready handshake with unbounded wait states.

Parameters:
ENABLE_ITYPE, 1, when 1 opcode 0010011 (addi etc.) is legal; when 0 it is treated as illegal
RETIRE_CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  7  IR[6:0], stable from DECODE until next fetch completes
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request valid
MemRead  out  1  read qualifier for mem_req
MemWrite  out  1  write qualifier for mem_req
AdrSrc  out  1  0 = PC, 1 = ALUOut
IRWrite  out  1  load IR (and OldPC) from read data
PCWrite  out  1  load PC from result bus
RegWrite  out  1  register file write enable
Branch  out  1  branch state indicator
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 (A reg)
ALUSrcB  out  2  00 rs2 (B reg), 01 immediate, 10 constant 4
ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
ResultSrc  out  2  00 ALUOut, 01 data reg, 10 ALU result
illegal_instr  out  1  one-cycle pulse on unsupported opcode
instr_done  out  1  one-cycle pulse when an instruction retires
retire_cnt  out  RETIRE_CNT_W  retired-instruction count, wraps

Behaviour:
- State register reset to FETCH; retire_cnt reset to 0. While rst_n=0, every strobe (mem_req, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, Branch, illegal_instr, instr_done) is 0, and all selects are 00. Reset mid-operation abandons the access; mem_req drops in the reset cycle.
- Unlisted outputs are 0 in each state.
- FETCH: mem_req=1, MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. Hold while mem_ready=0. In the mem_ready=1 cycle (Mealy), IRWrite=1 and PCWrite=1, then go to DECODE.
- DECODE (1 cycle): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state:
  - 0000011 or 0100011: MEMADR
  - 0110011: EXECUTER
  - 0010011 with ENABLE_ITYPE=1: EXECUTEI
  - 1100011: BEQ
  - any other opcode: FETCH, with illegal_instr=1 this cycle and no retire.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, MemRead=1, AdrSrc=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1, then FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. On mem_ready: instr_done=1, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, PCWrite=zero, instr_done=1, then FETCH.
- Handshake rules:
  - mem_req with its qualifier stays asserted and stable until the mem_ready cycle.
  - mem_ready outside a request state is ignored.
  - MemRead and MemWrite are never both 1.
- Latency with mem_ready tied to 1: R/I-type 4 cycles, beq 3, lw 5, sw 4.
- retire_cnt increments on each instr_done and wraps from all-ones to 0. An illegal opcode does not increment it.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, mem_ready=1. Expect all strobes 0 and retire_cnt=0. After release, the first cycle is FETCH with mem_req=1, MemRead=1, AdrSrc=0.
- R-type (0110011), mem_ready=1. Expect IRWrite/PCWrite in cycle 1, ALUOp=10 in cycle 3, RegWrite with ResultSrc=00 in cycle 4, instr_done=1, retire_cnt=1.
- lw (0000011) with mem_ready held low 3 cycles in MEMREAD. Expect mem_req/MemRead/AdrSrc=1 stable for 4 cycles, then MEMWB RegWrite with ResultSrc=01; total 8 cycles.
- beq (1100011): with zero=1, PCWrite=1 and Branch=1 in BEQ. Repeat with zero=0: PCWrite=0, and instr_done=1 in both cases.
- Illegal opcode 1111111 (and 0010011 with ENABLE_ITYPE=0). Expect illegal_instr pulse in DECODE, return to FETCH next cycle, retire_cnt unchanged.
- sw (0100011) with rst_n pulled low during the MEMWRITE wait. Expect mem_req and MemWrite to drop in the reset cycle, no instr_done, and FETCH after release.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle sequencing controller for the RV32 core: steps the shared ALU,
// unified memory port and register file through fetch/decode/execute/mem/wb.
//
// state      | meaning
// -----------+------------------------------------------------------------
// FETCH      | read instruction at PC, PC+4 into PC on mem_ready
// DECODE     | branch target into ALUOut, dispatch on opcode
// MEMADR     | rs1 + imm into ALUOut for lw/sw
// MEMREAD    | data read at ALUOut, wait for mem_ready
// MEMWB      | load data into rd
// MEMWRITE   | data write at ALUOut, wait for mem_ready
// EXECUTER   | rs1 op rs2
// EXECUTEI   | rs1 op imm
// ALUWB      | ALUOut into rd
// BEQ        | compare rs1/rs2, take branch on zero

module mc_control_fsm #(
   parameter int unsigned ENABLE_ITYPE = 1,
   parameter int unsigned RETIRE_CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              opcode,
   input  logic                    zero,
   input  logic                    mem_ready,
   output logic                    mem_req,
   output logic                    MemRead,
   output logic                    MemWrite,
   output logic                    AdrSrc,
   output logic                    IRWrite,
   output logic                    PCWrite,
   output logic                    RegWrite,
   output logic                    Branch,
   output logic [1:0]              ALUSrcA,
   output logic [1:0]              ALUSrcB,
   output logic [1:0]              ALUOp,
   output logic [1:0]              ResultSrc,
   output logic                    illegal_instr,
   output logic                    instr_done,
   output logic [RETIRE_CNT_W-1:0] retire_cnt
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic       ITYPE_OK = (ENABLE_ITYPE != 0);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BEQ
   } state_t;

   state_t state;
   state_t state_next;

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:    if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECUTER;
               OP_I:         state_next = ITYPE_OK ? S_EXECUTEI : S_FETCH;
               OP_BEQ:       state_next = S_BEQ;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
         S_EXECUTER: state_next = S_ALUWB;
         S_EXECUTEI: state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_BEQ:      state_next = S_FETCH;
         default:    state_next = S_FETCH;
      endcase
   end

   // Outputs are decoded from state plus the Mealy terms; gating on rst_n
   // drops every strobe in the reset cycle, abandoning any open access.
   always_comb begin
      mem_req       = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      RegWrite      = 1'b0;
      Branch        = 1'b0;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUOp         = 2'b00;
      ResultSrc     = 2'b00;
      illegal_instr = 1'b0;
      instr_done    = 1'b0;
      if (rst_n) begin
         case (state)
            S_FETCH: begin
               mem_req   = 1'b1;
               MemRead   = 1'b1;
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
            end
            S_DECODE: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b01;
               case (opcode)
                  OP_LW, OP_SW, OP_R, OP_BEQ: illegal_instr = 1'b0;
                  OP_I:                       illegal_instr = !ITYPE_OK;
                  default:                    illegal_instr = 1'b1;
               endcase
            end
            S_MEMADR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
               mem_req = 1'b1;
               MemRead = 1'b1;
               AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
               ResultSrc  = 2'b01;
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            S_MEMWRITE: begin
               mem_req    = 1'b1;
               MemWrite   = 1'b1;
               AdrSrc     = 1'b1;
               instr_done = mem_ready;
            end
            S_EXECUTER: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ALUOp   = 2'b10;
            end
            S_ALUWB: begin
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            S_BEQ: begin
               ALUSrcA    = 2'b10;
               ALUOp      = 2'b01;
               Branch     = 1'b1;
               PCWrite    = zero;
               instr_done = 1'b1;
            end
            default: begin
               mem_req = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         retire_cnt <= '0;
      end else begin
         state <= state_next;
         if (instr_done) retire_cnt <= retire_cnt + RETIRE_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected control vectors are
// queued as stimulus is driven and compared on the falling edge.

module tb_mc_control_fsm;

   localparam int P_RST  = 0;
   localparam int P_F    = 1;
   localparam int P_D    = 2;
   localparam int P_ILL  = 3;
   localparam int P_MA   = 4;
   localparam int P_MR   = 5;
   localparam int P_MWB  = 6;
   localparam int P_MW   = 7;
   localparam int P_EXR  = 8;
   localparam int P_EXI  = 9;
   localparam int P_AWB  = 10;
   localparam int P_BEQ  = 11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        zero;
   logic        mem_ready;

   logic        mem_req, MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Branch;
   logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
   logic        illegal_instr, instr_done;
   logic [31:0] retire_cnt;

   logic        mem_req2, MemRead2, MemWrite2, AdrSrc2, IRWrite2, PCWrite2, RegWrite2, Branch2;
   logic [1:0]  ALUSrcA2, ALUSrcB2, ALUOp2, ResultSrc2;
   logic        illegal_instr2, instr_done2;
   logic [2:0]  retire_cnt2;

   logic [17:0] obs, obs2;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_cnt = '0;
   logic [49:0] exp_q[$];
   int          ph_q[$];
   bit          sync2 = 1'b1;
   logic        noi_ill_exp = 1'b0;
   logic        noi_req_exp = 1'b0;
   logic [2:0]  noi_cnt_exp = '0;

   always #5 clk = ~clk;

   mc_control_fsm #(.ENABLE_ITYPE(1), .RETIRE_CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .Branch(Branch),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
      .illegal_instr(illegal_instr), .instr_done(instr_done), .retire_cnt(retire_cnt)
   );

   // Second instance: no I-type support and a 3-bit counter to exercise wrap.
   mc_control_fsm #(.ENABLE_ITYPE(0), .RETIRE_CNT_W(3)) u_dut_noi (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req2), .MemRead(MemRead2), .MemWrite(MemWrite2), .AdrSrc(AdrSrc2),
      .IRWrite(IRWrite2), .PCWrite(PCWrite2), .RegWrite(RegWrite2), .Branch(Branch2),
      .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .ResultSrc(ResultSrc2),
      .illegal_instr(illegal_instr2), .instr_done(instr_done2), .retire_cnt(retire_cnt2)
   );

   assign obs  = {mem_req, MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Branch,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal_instr, instr_done};
   assign obs2 = {mem_req2, MemRead2, MemWrite2, AdrSrc2, IRWrite2, PCWrite2, RegWrite2, Branch2,
                  ALUSrcA2, ALUSrcB2, ALUOp2, ResultSrc2, illegal_instr2, instr_done2};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected control vector for one cycle of a given phase.
   function automatic logic [17:0] ex(input int ph, input logic rdy, input logic z);
      logic req, rd, wr, adr, irw, pcw, rw, br, ill, dn;
      logic [1:0] a, b, op, rs;
      {req, rd, wr, adr, irw, pcw, rw, br, ill, dn} = '0;
      {a, b, op, rs} = '0;
      case (ph)
         P_F:   begin req = 1; rd = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
         P_D:   begin a = 2'b01; b = 2'b01; end
         P_ILL: begin a = 2'b01; b = 2'b01; ill = 1; end
         P_MA:  begin a = 2'b10; b = 2'b01; end
         P_MR:  begin req = 1; rd = 1; adr = 1; end
         P_MWB: begin rs = 2'b01; rw = 1; dn = 1; end
         P_MW:  begin req = 1; wr = 1; adr = 1; dn = rdy; end
         P_EXR: begin a = 2'b10; b = 2'b00; op = 2'b10; end
         P_EXI: begin a = 2'b10; b = 2'b01; op = 2'b10; end
         P_AWB: begin rs = 2'b00; rw = 1; dn = 1; end
         P_BEQ: begin a = 2'b10; op = 2'b01; br = 1; pcw = z; dn = 1; end
         default: ;
      endcase
      return {req, rd, wr, adr, irw, pcw, rw, br, a, b, op, rs, ill, dn};
   endfunction

   task automatic cyc(input int ph, input logic rdy, input logic z);
      logic [17:0] e;
      logic [49:0] pop;
      int          p;
      rst_n     = (ph != P_RST);
      mem_ready = rdy;
      zero      = z;
      e = ex(ph, rdy, z);
      exp_q.push_back({e, exp_cnt});
      ph_q.push_back(ph);
      @(negedge clk);
      pop = exp_q.pop_front();
      p   = ph_q.pop_front();
      chk($sformatf("ctl_ph%0d", p), {14'd0, obs}, {14'd0, pop[49:32]});
      chk($sformatf("cnt_ph%0d", p), retire_cnt, pop[31:0]);
      if (sync2) begin
         chk($sformatf("noi_ctl_ph%0d", p), {14'd0, obs2}, {14'd0, pop[49:32]});
         chk($sformatf("noi_cnt_ph%0d", p), {29'd0, retire_cnt2}, {29'd0, pop[2:0]});
      end else begin
         chk("noi_ill", {31'd0, illegal_instr2}, {31'd0, noi_ill_exp});
         chk("noi_req", {31'd0, mem_req2}, {31'd0, noi_req_exp});
         chk("noi_cnt_hold", {29'd0, retire_cnt2}, {29'd0, noi_cnt_exp});
      end
      if (e[0]) exp_cnt = exp_cnt + 1;
      if (ph == P_RST) exp_cnt = '0;
      @(posedge clk);
      #1;
   endtask

   function automatic logic rnd();
      return logic'($urandom_range(0, 1));
   endfunction

   task automatic do_r();
      opcode = 7'b0110011;
      cyc(P_F, 1, 0); cyc(P_D, rnd(), 0); cyc(P_EXR, rnd(), 0); cyc(P_AWB, rnd(), 0);
   endtask

   task automatic do_lw(input int waits);
      opcode = 7'b0000011;
      cyc(P_F, 1, 0); cyc(P_D, rnd(), 0); cyc(P_MA, rnd(), 0);
      for (int i = 0; i < waits; i++) cyc(P_MR, 0, 0);
      cyc(P_MR, 1, 0); cyc(P_MWB, rnd(), 0);
   endtask

   task automatic do_sw(input int waits);
      opcode = 7'b0100011;
      cyc(P_F, 1, 0); cyc(P_D, rnd(), 0); cyc(P_MA, rnd(), 0);
      for (int i = 0; i < waits; i++) cyc(P_MW, 0, 0);
      cyc(P_MW, 1, 0);
   endtask

   task automatic do_beq(input logic z);
      opcode = 7'b1100011;
      cyc(P_F, 1, z); cyc(P_D, rnd(), z); cyc(P_BEQ, rnd(), z);
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 7'd0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) cyc(P_RST, 1, 0);

      do_r();
      do_lw(3);
      do_beq(1);
      do_beq(0);

      opcode = 7'b1111111;
      cyc(P_F, 0, 0); cyc(P_F, 1, 0); cyc(P_ILL, 1, 0);

      opcode = 7'b0100011;
      cyc(P_F, 1, 0); cyc(P_D, 1, 0); cyc(P_MA, 1, 0);
      cyc(P_MW, 0, 0); cyc(P_MW, 0, 0); cyc(P_RST, 0, 0);

      do_r();
      for (int i = 0; i < 10; i++) begin
         case (i % 3)
            0: do_r();
            1: do_beq(i[1]);
            default: do_sw(int'($urandom_range(0, 2)));
         endcase
      end
      do_lw(0);

      // addi: legal on the main instance, illegal on the no-I-type instance
      opcode = 7'b0010011;
      cyc(P_F, 1, 0);
      sync2 = 1'b0;
      noi_cnt_exp = exp_cnt[2:0];
      noi_ill_exp = 1'b1; noi_req_exp = 1'b0;
      cyc(P_D, 0, 0);
      noi_ill_exp = 1'b0; noi_req_exp = 1'b1;
      cyc(P_EXI, 0, 0);
      cyc(P_AWB, 0, 0);
      noi_req_exp = 1'b0;
      cyc(P_RST, 0, 0);
      sync2 = 1'b1;
      do_r();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
